// File: rtl/video_timing_gen.sv
// Combined horizontal/vertical video timing generator with a staged
// configuration set that is swapped in atomically at the frame boundary.
module video_timing_gen #(
  parameter int CNT_WIDTH = 12,
  parameter int H_RES     = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_RES     = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int IRQ_LINE  = 480,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 cfg_write,
  input  logic [3:0]           cfg_sel,
  input  logic [CNT_WIDTH-1:0] cfg_data,
  input  logic                 cfg_commit,
  output logic                 cfg_pending,
  output logic [CNT_WIDTH-1:0] x,
  output logic [CNT_WIDTH-1:0] y,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 hblank,
  output logic                 vblank,
  output logic                 blank,
  output logic                 frame_start,
  output logic                 line_start,
  output logic                 line_irq
);
  localparam int SW = CNT_WIDTH + 2;
  localparam int NF = 9;

  typedef logic [CNT_WIDTH-1:0]          field_t;
  typedef logic [SW-1:0]                 sum_t;
  typedef logic [NF-1:0][CNT_WIDTH-1:0]  set_t;

  // Field index order: h_res, h_fp, h_sync, h_bp, v_res, v_fp, v_sync, v_bp, irq_line
  localparam set_t DFLT = {field_t'(IRQ_LINE), field_t'(V_BP), field_t'(V_SYNC),
                           field_t'(V_FP), field_t'(V_RES), field_t'(H_BP),
                           field_t'(H_SYNC), field_t'(H_FP), field_t'(H_RES)};

  function automatic sum_t ext(input field_t f);
    return {2'b00, f};
  endfunction

  field_t r_x;
  field_t r_y;
  logic   r_pending;
  set_t   r_act;
  set_t   r_stg;

  set_t   w_stg_nxt;
  logic   w_pend_nxt;
  sum_t   w_ht;
  sum_t   w_vt;
  sum_t   w_hs_beg;
  sum_t   w_hs_end;
  sum_t   w_vs_beg;
  sum_t   w_vs_end;
  logic   w_x_last;
  logic   w_y_last;
  logic   w_wrap;

  always_comb begin
    w_stg_nxt = r_stg;
    if (cfg_write && (cfg_sel < 4'(NF))) w_stg_nxt[cfg_sel] = cfg_data;
  end

  assign w_pend_nxt = r_pending | cfg_commit;

  assign w_hs_beg = ext(r_act[0]) + ext(r_act[1]);
  assign w_hs_end = w_hs_beg + ext(r_act[2]);
  assign w_ht     = w_hs_end + ext(r_act[3]);
  assign w_vs_beg = ext(r_act[4]) + ext(r_act[5]);
  assign w_vs_end = w_vs_beg + ext(r_act[6]);
  assign w_vt     = w_vs_end + ext(r_act[7]);

  assign w_x_last = (ext(r_x) == (w_ht - sum_t'(1)));
  assign w_y_last = (ext(r_y) == (w_vt - sum_t'(1)));
  assign w_wrap   = enable && w_x_last && w_y_last;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_x       <= '0;
      r_y       <= '0;
      r_pending <= 1'b0;
      r_act     <= DFLT;
      r_stg     <= DFLT;
    end else begin
      r_stg <= w_stg_nxt;
      if (enable) begin
        if (w_x_last) begin
          r_x <= '0;
          r_y <= w_y_last ? '0 : r_y + field_t'(1);
        end else begin
          r_x <= r_x + field_t'(1);
        end
      end
      // Same-cycle writes/commit are folded into the swap so nothing is lost.
      if (w_wrap && w_pend_nxt) begin
        r_act     <= w_stg_nxt;
        r_pending <= 1'b0;
      end else begin
        r_pending <= w_pend_nxt;
      end
    end
  end

  // Outputs decode straight from the counter and active-set flops.
  assign x           = r_x;
  assign y           = r_y;
  assign cfg_pending = r_pending;
  assign hblank      = (r_x >= r_act[0]);
  assign vblank      = (r_y >= r_act[4]);
  assign blank       = hblank | vblank;
  assign hsync       = ((ext(r_x) >= w_hs_beg) && (ext(r_x) < w_hs_end)) ? H_POL : ~H_POL;
  assign vsync       = ((ext(r_y) >= w_vs_beg) && (ext(r_y) < w_vs_end)) ? V_POL : ~V_POL;
  assign line_start  = (r_x == '0);
  assign frame_start = line_start && (r_y == '0);
  assign line_irq    = line_start && (r_y == r_act[8]);

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: linear pixel-index reference model compared every
// cycle, plus directed literal checks on a scaled-down timing.
module tb_video_timing_gen;
  localparam int CW      = 12;
  localparam int TH_RES  = 40;
  localparam int TH_FP   = 4;
  localparam int TH_SYNC = 6;
  localparam int TH_BP   = 3;
  localparam int TV_RES  = 20;
  localparam int TV_FP   = 2;
  localparam int TV_SYNC = 2;
  localparam int TV_BP   = 3;
  localparam int TIRQ    = 20;
  localparam bit TH_POL  = 1'b0;
  localparam bit TV_POL  = 1'b0;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          cfg_write;
  logic [3:0]    cfg_sel;
  logic [CW-1:0] cfg_data;
  logic          cfg_commit;
  logic          cfg_pending;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          hsync, vsync, hblank, vblank, blank;
  logic          frame_start, line_start, line_irq;

  int n_cmp = 0;
  int n_bad = 0;

  video_timing_gen #(
    .CNT_WIDTH(CW), .H_RES(TH_RES), .H_FP(TH_FP), .H_SYNC(TH_SYNC), .H_BP(TH_BP),
    .V_RES(TV_RES), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP),
    .IRQ_LINE(TIRQ), .H_POL(TH_POL), .V_POL(TV_POL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_write(cfg_write),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .cfg_pending(cfg_pending), .x(x), .y(y), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .vblank(vblank), .blank(blank), .frame_start(frame_start),
    .line_start(line_start), .line_irq(line_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: position is a single pixel index within the frame.
  int m_act [9];
  int m_stg [9];
  int m_p    = 0;
  bit m_pend = 1'b0;
  bit m_ok   = 1'b0;

  function automatic int dflt_of(input int i);
    case (i)
      0: return TH_RES;  1: return TH_FP;  2: return TH_SYNC; 3: return TH_BP;
      4: return TV_RES;  5: return TV_FP;  6: return TV_SYNC; 7: return TV_BP;
      default: return TIRQ;
    endcase
  endfunction

  function automatic int m_ht();
    return m_act[0] + m_act[1] + m_act[2] + m_act[3];
  endfunction

  function automatic int m_vt();
    return m_act[4] + m_act[5] + m_act[6] + m_act[7];
  endfunction

  function automatic logic [32:0] model_out();
    int hx, hy, hsb, vsb;
    logic hs, vs, hb, vb;
    hx  = m_p % m_ht();
    hy  = m_p / m_ht();
    hsb = m_act[0] + m_act[1];
    vsb = m_act[4] + m_act[5];
    hs  = (hx >= hsb && hx < hsb + m_act[2]) ? TH_POL : !TH_POL;
    vs  = (hy >= vsb && hy < vsb + m_act[6]) ? TV_POL : !TV_POL;
    hb  = (hx >= m_act[0]);
    vb  = (hy >= m_act[4]);
    return {m_pend, CW'(hx), CW'(hy), hs, vs, hb, vb, hb | vb,
            (hx == 0 && hy == 0), (hx == 0), (hx == 0 && hy == m_act[8])};
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_p    = 0;
      m_pend = 1'b0;
      for (int i = 0; i < 9; i++) begin
        m_act[i] = dflt_of(i);
        m_stg[i] = dflt_of(i);
      end
      m_ok = 1'b1;
    end else if (m_ok) begin
      if (cfg_write && int'(cfg_sel) < 9) m_stg[int'(cfg_sel)] = int'(cfg_data);
      if (cfg_commit) m_pend = 1'b1;
      if (enable) begin
        m_p++;
        if (m_p == m_ht() * m_vt()) begin
          m_p = 0;
          if (m_pend) begin
            m_act  = m_stg;
            m_pend = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok)
      chk("cycle_outputs",
          {31'd0, cfg_pending, x, y, hsync, vsync, hblank, vblank, blank,
           frame_start, line_start, line_irq},
          {31'd0, model_out()});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [3:0] sel, input logic [CW-1:0] d);
    cfg_write = 1'b1; cfg_sel = sel; cfg_data = d;
    tick();
    cfg_write = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_pending"}, cfg_pending, 0);
    chk({tag, "_hsync"}, hsync, 1);
    chk({tag, "_vsync"}, vsync, 1);
    chk({tag, "_hblank"}, hblank, 0);
    chk({tag, "_vblank"}, vblank, 0);
    chk({tag, "_blank"}, blank, 0);
    chk({tag, "_frame_start"}, frame_start, 1);
    chk({tag, "_line_start"}, line_start, 1);
    chk({tag, "_line_irq"}, line_irq, 0);
  endtask

  initial begin
    int n_hs, n_vs, n_vb, n_irq, n_ls;
    bit found;
    reset_n = 1'b0; enable = 1'b0; cfg_write = 1'b1; cfg_sel = 4'd0;
    cfg_data = 12'd7; cfg_commit = 1'b1;
    tick();
    cfg_write = 1'b0; cfg_commit = 1'b0;
    tick();
    chk_reset_vals("rst");

    // Default timing, one full frame (HT=53, VT=27)
    reset_n = 1'b1; enable = 1'b1;
    n_hs = 0; n_vs = 0; n_vb = 0; n_irq = 0; n_ls = 0;
    for (int i = 0; i < 1431; i++) begin
      if (hsync == 1'b0) n_hs++;
      if (vsync == 1'b0) n_vs++;
      if (vblank) n_vb++;
      if (line_irq) n_irq++;
      if (line_start) n_ls++;
      if (i == 39) chk("hblank_x39", hblank, 0);
      if (i == 40) chk("hblank_x40", hblank, 1);
      if (i == 43) chk("hsync_x43", hsync, 1);
      if (i == 44) chk("hsync_x44", hsync, 0);
      if (i == 49) chk("hsync_x49", hsync, 0);
      if (i == 50) chk("hsync_x50", hsync, 1);
      if (i == 53) chk("y_step_53", {x, y}, {12'd0, 12'd1});
      if (i == 1060) chk("irq_y20", line_irq, 1);
      if (i == 1166) chk("vsync_y22", vsync, 0);
      tick();
    end
    chk("hsync_low_count", n_hs, 162);
    chk("vsync_low_count", n_vs, 106);
    chk("vblank_count", n_vb, 371);
    chk("line_irq_count", n_irq, 1);
    chk("line_start_count", n_ls, 27);
    chk("frame_start_again", {frame_start, x, y}, {1'b1, 12'd0, 12'd0});

    // Enable toggled every cycle: one line takes 106 clocks
    for (int i = 0; i < 106; i++) begin
      enable = (i % 2 == 0);
      tick();
      if (i == 0) chk("toggle_adv", x, 1);
      if (i == 1) chk("toggle_hold", x, 1);
    end
    chk("toggle_line_done", {x, y}, {12'd0, 12'd1});
    enable = 1'b1;

    // Stage new horizontal timing and commit mid-frame
    wr(4'd0, 12'd320); wr(4'd1, 12'd8); wr(4'd2, 12'd48); wr(4'd3, 12'd24);
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    chk("pending_set", cfg_pending, 1);
    chk("old_timing_pos", {x, y}, {12'd5, 12'd1});
    ticks(47);
    chk("old_ht_last", x, 52);
    tick();
    chk("old_ht_wrap", {cfg_pending, x, y}, {1'b1, 12'd0, 12'd2});
    for (int i = 0; i < 2000 && !frame_start; i++) tick();
    chk("commit_wrap_seen", frame_start, 1);
    chk("pending_cleared", cfg_pending, 0);
    ticks(327);
    chk("new_hsync_x327", {x, hsync}, {12'd327, 1'b1});
    tick();
    chk("new_hsync_x328", hsync, 0);
    ticks(47);
    chk("new_hsync_x375", {x, hsync}, {12'd375, 1'b0});
    tick();
    chk("new_hsync_x376", hsync, 1);
    ticks(23);
    chk("new_ht_last", x, 399);
    tick();
    chk("new_ht_400", {x, y}, {12'd0, 12'd1});

    // h_sync=0 staged, commit in the exact frame-wrap cycle
    wr(4'd2, 12'd0);
    found = 1'b0;
    for (int i = 0; i < 12000; i++) begin
      if (x == 12'd399 && y == 12'd26) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_wrap_cycle", found, 1);
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    chk("wrap_commit_applied", {cfg_pending, frame_start}, {1'b0, 1'b1});
    n_hs = 0;
    for (int i = 0; i < 9504; i++) begin
      if (hsync == 1'b0) n_hs++;
      if (i == 352) chk("ht_352", {x, y}, {12'd0, 12'd1});
      tick();
    end
    chk("nosync_hsync_low", n_hs, 0);
    chk("nosync_frame_len", frame_start, 1);

    // Reset mid-frame with a commit pending
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    ticks(3819);
    chk("pre_reset_pos", {cfg_pending, x, y}, {1'b1, 12'd300, 12'd10});
    reset_n = 1'b0; cfg_write = 1'b1; cfg_sel = 4'd0; cfg_data = 12'd5; cfg_commit = 1'b1;
    tick();
    reset_n = 1'b1; cfg_write = 1'b0; cfg_commit = 1'b0;
    chk_reset_vals("midrst");
    ticks(53);
    chk("dflt_ht_after_rst", {x, y}, {12'd0, 12'd1});
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    for (int i = 0; i < 2000 && !frame_start; i++) tick();
    chk("stg_wrap_seen", {cfg_pending, frame_start}, {1'b0, 1'b1});
    ticks(53);
    chk("stg_dflt_ht", {x, y}, {12'd0, 12'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
